// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, arbiter state encoding and a wrap helper.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, ARB, LOCK} arb_state_t;
    localparam logic START = 1'b0;
    localparam logic STOP = 1'b1;
    localparam int DATA_BITS = 8;
    localparam int CLKS_PER_BIT_DEF = 434;
    function automatic int rr_wrap(input int v, input int n);
        return v >= n ? v - n : v;
    endfunction
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: bit timer and 8N1 serializer; done marks the last cycle of the stop bit.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS + 1);
    logic [CW-1:0] cyc;
    logic [3:0] bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic bit_end;
    assign bit_end = cyc == CW'(CLKS_PER_BIT - 1);
    assign done = busy && bit_end && bit_idx == LAST_BIT;
    // Idle line is driven from busy so an asynchronous reset releases tx at once.
    assign tx = !busy ? STOP : bit_idx == '0 ? START : bit_idx == LAST_BIT ? STOP : shreg[0];
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cyc <= '0;
            bit_idx <= '0;
            shreg <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cyc <= '0;
            bit_idx <= '0;
            shreg <= data;
        end else if (busy) begin
            cyc <= bit_end ? '0 : cyc + 1'b1;
            if (bit_end) begin
                busy <= bit_idx != LAST_BIT;
                bit_idx <= bit_idx == LAST_BIT ? '0 : bit_idx + 1'b1;
                shreg <= bit_idx == '0 ? shreg : shreg >> 1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one UART transmitter.
// Define UART_ARB_LOCK_TIMEOUT_EN to drop a lock left idle for LOCK_TIMEOUT_BITS bit periods.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int LOCK_TIMEOUT_BITS = 16
) (
    input  logic                       clk_50M,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       tx
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_t state, state_n;
    logic [IW-1:0] ptr, ptr_n, grant_n, sel, grant_inc;
    logic [7:0] data_sel;
    logic core_busy, core_done, core_ready, accept, pkt_end, timeout;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || CLKS_PER_BIT < 4 || LOCK_TIMEOUT_BITS < 1) begin : g_bad_param
            $error("uart_tx_arbiter: parameter out of range");
        end
    endgenerate

    // A new byte may enter as the previous stop bit finishes, keeping frames gap-free.
    assign core_ready = !core_busy || core_done;
    assign accept = state == LOCK && req_valid[grant_id] && core_ready;
    assign pkt_end = accept && req_last[grant_id];
    assign req_ready = accept ? NUM_REQ'(1) << grant_id : '0;
    assign data_sel = req_data[8*grant_id +: 8];
    assign grant_inc = IW'(rr_wrap(int'(grant_id) + 1, NUM_REQ));
    assign busy = state != IDLE || core_busy;

    // Lowest offset from the pointer wins, so scan downward and let later hits override.
    always_comb begin
        sel = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[IW'(rr_wrap(int'(ptr) + i, NUM_REQ))]) sel = IW'(rr_wrap(int'(ptr) + i, NUM_REQ));
    end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    localparam int TO_CYCLES = LOCK_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TO_CYCLES);
    logic [TW-1:0] to_cnt;
    assign timeout = state == LOCK && !core_busy && !accept && to_cnt == TW'(TO_CYCLES - 1);
    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n) to_cnt <= '0;
        else to_cnt <= (state == LOCK && !core_busy && !accept) ? to_cnt + 1'b1 : '0;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            grant_id <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            grant_id <= grant_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_id;
        ptr_n = ptr;
        case (state)
            IDLE: state_n = |req_valid ? ARB : IDLE;
            ARB: begin
                state_n = |req_valid ? LOCK : IDLE;
                grant_n = |req_valid ? sel : grant_id;
            end
            LOCK: if (pkt_end || timeout) begin
                state_n = IDLE;
                ptr_n = grant_inc;
            end
            default: state_n = IDLE;
        endcase
    end

    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk_50M(clk_50M),
        .rst_n(rst_n),
        .start(accept),
        .data(data_sel),
        .tx(tx),
        .busy(core_busy),
        .done(core_done)
    );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests of framing, round-robin order, packet locking and reset.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int CPB = 4;
    logic clk_50M = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_last = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic [1:0] grant_id;
    logic busy, tx;
    int errors = 0, checks = 0, cyc = 0, frame_err = 0;
    logic [8:0] q[N][$];
    int acc_id[$], acc_byte[$], acc_cyc[$];
    int ln_byte[$], ln_start[$], ln_grant[$];
    int exp_id[$], exp_b[$];
    logic [39:0] seq;
    logic tx_low;

    uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .LOCK_TIMEOUT_BITS(2)) dut (
        .clk_50M(clk_50M),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant_id(grant_id),
        .busy(busy),
        .tx(tx)
    );

    initial forever #5 clk_50M = ~clk_50M;
    initial forever begin
        @(posedge clk_50M);
        cyc++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester model: presents the head of its queue and pops it once accepted.
    initial forever begin : drv
        logic [N-1:0] acc;
        @(negedge clk_50M);
        acc = req_valid & req_ready;
        for (int k = 0; k < N; k++)
            if (acc[k] === 1'b1) begin
                acc_id.push_back(k);
                acc_byte.push_back(int'(req_data[k*8 +: 8]));
                acc_cyc.push_back(cyc);
            end
        @(posedge clk_50M);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k] === 1'b1 && q[k].size() > 0) void'(q[k].pop_front());
            req_valid[k] = q[k].size() > 0;
            req_data[k*8 +: 8] = q[k].size() > 0 ? q[k][0][7:0] : 8'h00;
            req_last[k] = q[k].size() > 0 && q[k][0][8];
        end
    end

    // Line monitor: decodes complete frames, discarding any cut short by reset.
    initial forever begin : mon
        int s, g, fe;
        logic [7:0] b;
        logic bad;
        @(negedge clk_50M);
        if (rst_n === 1'b1 && tx === 1'b0) begin
            s = cyc;
            g = int'(grant_id);
            b = '0;
            bad = 1'b0;
            fe = 0;
            for (int j = 1; j < 40; j++) begin
                @(negedge clk_50M);
                if (rst_n !== 1'b1) bad = 1'b1;
                if (j == 2 && tx !== 1'b0) fe++;
                if (j == 38 && tx !== 1'b1) fe++;
                if (j % 4 == 2 && j >= 6 && j <= 34) b[j/4-1] = tx;
            end
            if (!bad) begin
                ln_byte.push_back(int'(b));
                ln_start.push_back(s);
                ln_grant.push_back(g);
                frame_err += fe;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);
    endtask

    task automatic clear_logs();
        acc_id.delete();
        acc_byte.delete();
        acc_cyc.delete();
        ln_byte.delete();
        ln_start.delete();
        ln_grant.delete();
    endtask

    task automatic wait_ready(input int k, input int budget);
        int n = 0;
        do begin
            @(negedge clk_50M);
            n++;
        end while (req_ready[k] !== 1'b1 && n < budget);
        chk("ready_wait", req_ready[k], 1);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (ln_byte.size() < n && t < budget) begin
            @(negedge clk_50M);
            t++;
        end
        chk("frame_wait", ln_byte.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((busy !== 1'b0 || req_valid != '0) && t < budget) begin
            @(negedge clk_50M);
            t++;
        end
        chk("idle_wait", busy, 0);
        repeat (2) @(negedge clk_50M);
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_nacc"}, acc_id.size(), exp_id.size());
        chk({tag, "_nline"}, ln_byte.size(), exp_b.size());
        for (int i = 0; i < exp_id.size(); i++) begin
            chk({tag, "_id"}, i < acc_id.size() ? acc_id[i] : -1, exp_id[i]);
            chk({tag, "_acc_byte"}, i < acc_byte.size() ? acc_byte[i] : -1, exp_b[i]);
            chk({tag, "_line_byte"}, i < ln_byte.size() ? ln_byte[i] : -1, exp_b[i]);
            chk({tag, "_grant"}, i < ln_grant.size() ? ln_grant[i] : -1, exp_id[i]);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_50M);
        chk("rst_tx", tx, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50M);

        // Test 1: single 0x47 frame, exact bit pattern and busy release
        q[0].push_back({1'b1, 8'h47});
        wait_ready(0, 20);
        seq = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50M);
            seq = {seq[38:0], tx};
            if (i == 39) chk("t1_busy_stop", busy, 1);
        end
        chk("t1_seq", seq, 40'h0FFF000F0F);
        @(negedge clk_50M);
        chk("t1_busy_after", busy, 0);
        chk("t1_tx_idle", tx, 1);

        // Test 2: four simultaneous single-byte packets after reset
        do_reset();
        clear_logs();
        q[0].push_back({1'b1, 8'h10});
        q[1].push_back({1'b1, 8'h21});
        q[2].push_back({1'b1, 8'h32});
        q[3].push_back({1'b1, 8'h43});
        wait_frames(4, 400);
        exp_id = '{0, 1, 2, 3};
        exp_b = '{'h10, 'h21, 'h32, 'h43};
        check_logs("t2");
        for (int i = 1; i < 4; i++)
            chk("t2_gap", i < ln_start.size() ? ln_start[i] - ln_start[i-1] : -1, 40);
        wait_idle(200);

        // Test 3: 3-byte packet from 2 holds the lock against 1 and 3
        clear_logs();
        q[2].push_back({1'b0, 8'hA1});
        q[2].push_back({1'b0, 8'hB2});
        q[2].push_back({1'b1, 8'hC3});
        wait_ready(2, 20);
        q[1].push_back({1'b1, 8'h5A});
        q[3].push_back({1'b1, 8'h6B});
        wait_frames(5, 600);
        exp_id = '{2, 2, 2, 3, 1};
        exp_b = '{'hA1, 'hB2, 'hC3, 'h6B, 'h5A};
        check_logs("t3");
        wait_idle(200);

        // Withdrawn request: no frame, no lock, pointer still at 2
        clear_logs();
        q[1].push_back({1'b1, 8'h77});
        @(negedge clk_50M);
        q[1].delete();
        repeat (60) @(negedge clk_50M);
        chk("drop_nacc", acc_id.size(), 0);
        chk("drop_nline", ln_byte.size(), 0);
        chk("drop_busy", busy, 0);
        q[1].push_back({1'b1, 8'h12});
        q[3].push_back({1'b1, 8'h34});
        wait_frames(2, 300);
        exp_id = '{3, 1};
        exp_b = '{'h34, 'h12};
        check_logs("drop");
        wait_idle(200);

        // Test 4: reset during data bit 3
        clear_logs();
        q[2].push_back({1'b1, 8'h00});
        wait_ready(2, 20);
        repeat (18) @(negedge clk_50M);
        chk("t4_tx_bit3", tx, 0);
        chk("t4_grant_pre", grant_id, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_tx_async", tx, 1);
        chk("t4_busy_rst", busy, 0);
        chk("t4_ready_rst", req_ready, 0);
        chk("t4_grant_rst", grant_id, 0);
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        clear_logs();
        tx_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_50M);
            if (tx !== 1'b1) tx_low = 1'b1;
        end
        chk("t4_tx_stays_idle", tx_low, 0);
        chk("t4_busy_idle", busy, 0);
        chk("t4_nacc", acc_id.size(), 0);
        chk("t4_nline", ln_byte.size(), 0);

        clear_logs();
        q[1].push_back({1'b0, 8'h11});
        wait_ready(1, 20);
        q[3].push_back({1'b1, 8'h33});
`ifdef UART_ARB_LOCK_TIMEOUT_EN
        // Test 5: idle lock dropped after 2 bit periods, then requester 3 served
        wait_frames(2, 300);
        exp_id = '{1, 3};
        exp_b = '{'h11, 'h33};
        check_logs("t5");
        chk("t5_timeout_cycles", acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1, 51);
`else
        // Lock without timeout: requester 3 waits until requester 1 ends its packet
        repeat (150) @(negedge clk_50M);
        chk("t6_hold_nacc", acc_id.size(), 1);
        chk("t6_hold_busy", busy, 1);
        chk("t6_hold_grant", grant_id, 1);
        q[1].push_back({1'b1, 8'h22});
        wait_frames(3, 300);
        exp_id = '{1, 1, 3};
        exp_b = '{'h11, 'h22, 'h33};
        check_logs("t6");
`endif
        wait_idle(200);
        chk("framing", frame_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
